// File: rtl/fetch_stage_pkg.sv
// Shared pipeline package: fetch-stage parameter defaults and FSM state type.
package fetch_stage_pkg;

    localparam int unsigned DefPcWidth    = 64;
    localparam int unsigned DefInstrWidth = 32;
    localparam logic [63:0] DefResetPc    = 64'h0;

    // StReq: a request may be presented, StWait: one request outstanding,
    // StDrop: the outstanding request was overtaken by a redirect.
    typedef enum logic [1:0] {
        StReq,
        StWait,
        StDrop
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer between fetch and decode, with flush.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = DefPcWidth,
    parameter int unsigned INSTR_WIDTH = DefInstrWidth
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [PC_WIDTH-1:0]    push_pc_i,
    input  logic [INSTR_WIDTH-1:0] push_instr_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [PC_WIDTH-1:0]    head_pc_o,
    output logic [INSTR_WIDTH-1:0] head_instr_o
);

    logic [PC_WIDTH-1:0]    pc_q    [2];
    logic [INSTR_WIDTH-1:0] instr_q [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             cnt_q, cnt_d;

    assign full_o       = (cnt_q == 2'd2);
    assign empty_o      = (cnt_q == 2'd0);
    assign head_pc_o    = pc_q[rd_ptr_q];
    assign head_instr_o = instr_q[rd_ptr_q];

    // Pointer and occupancy next-state; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push_i) wr_ptr_d = ~wr_ptr_q;
            if (pop_i)  rd_ptr_d = ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
        end else if (push_i && !flush_i) begin
            pc_q[wr_ptr_q]    <= push_pc_i;
            instr_q[wr_ptr_q] <= push_instr_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, 2-entry buffer to decode,
// redirect support with stale-response dropping.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = DefPcWidth,
    parameter int unsigned         INSTR_WIDTH = DefInstrWidth,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DefResetPc)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   imem_req_valid_o,
    input  logic                   imem_req_ready_i,
    output logic [PC_WIDTH-1:0]    imem_req_addr_o,
    input  logic                   imem_resp_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [PC_WIDTH-1:0]    id_pc_o,
    output logic [INSTR_WIDTH-1:0] id_instr_o
);

    fetch_state_e        state_q;
    logic [PC_WIDTH-1:0] fetch_pc_q;
    logic [PC_WIDTH-1:0] req_pc_q;
    logic                run_q;

    logic                req_fire;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [PC_WIDTH-1:0] redirect_target;

    // Word-align the target by masking, which keeps every input bit in use.
    assign redirect_target = redirect_pc_i & ~PC_WIDTH'(3);

    // run_q holds requests off while in reset and for the release cycle.
    assign imem_req_valid_o = run_q && (state_q == StReq) && !fifo_full;
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // A response arriving alongside a redirect is stale and never pushed.
    assign push       = (state_q == StWait) && imem_resp_valid_i && !redirect_valid_i;
    assign id_valid_o = !fifo_empty && !redirect_valid_i;
    assign pop        = id_valid_o && id_ready_i;

    // Request FSM with fetch PC and outstanding-request PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StReq;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            run_q      <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (redirect_valid_i) begin
                fetch_pc_q <= redirect_target;
            end else if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + PC_WIDTH'(4);
            end
            if (req_fire) begin
                req_pc_q <= fetch_pc_q;
            end
            unique case (state_q)
                StReq: begin
                    if (req_fire) state_q <= redirect_valid_i ? StDrop : StWait;
                end
                StWait: begin
                    // A response in this cycle retires the request even if stale.
                    if (imem_resp_valid_i)     state_q <= StReq;
                    else if (redirect_valid_i) state_q <= StDrop;
                end
                StDrop: begin
                    if (imem_resp_valid_i) state_q <= StReq;
                end
                default: state_q <= StReq;
            endcase
        end
    end

    fetch_fifo #(
        .PC_WIDTH   (PC_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_pc_i   (req_pc_q),
        .push_instr_i(imem_resp_data_i),
        .pop_i       (pop),
        .flush_i     (redirect_valid_i),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_pc_o   (id_pc_o),
        .head_instr_o(id_instr_o)
    );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_WIDTH, default 64, SHALL set the width of all PC/address signals.
REQ-002 Parameter INSTR_WIDTH, default 32, SHALL set the instruction word width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the first fetch address after reset.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 redirect_valid  input  1  next-PC override from the pc_change stage (branch taken/jal/jalr).
REQ-007 redirect_pc  input  PC_WIDTH  redirect target.
REQ-008 imem_req_valid  output  1  instruction-memory request valid.
REQ-009 imem_req_ready  input  1  memory accepts request.
REQ-010 imem_req_addr  output  PC_WIDTH  request address.
REQ-011 imem_resp_valid  input  1  response valid; SHALL be asserted for exactly one cycle per accepted request, at least one cycle after acceptance.
REQ-012 imem_resp_data  input  INSTR_WIDTH  fetched instruction.
REQ-013 id_valid  output  1  instruction available to decode.
REQ-014 id_ready  input  1  decode accepts; pop when id_valid && id_ready.
REQ-015 id_pc  output  PC_WIDTH  PC of the head instruction.
REQ-016 id_instr  output  INSTR_WIDTH  head instruction.

Function
REQ-017 FSM states SHALL be REQ (request may be presented), WAIT (one request outstanding), DROP (outstanding request stale).
REQ-018 At most one memory request SHALL be outstanding.
REQ-019 In REQ, imem_req_valid SHALL be 1 iff buffer occupancy < 2, with imem_req_addr = fetch_pc.
REQ-020 Once asserted, imem_req_valid SHALL stay 1 until accepted; imem_req_addr SHALL change only on a redirect.
REQ-021 On acceptance (valid && ready) the FSM SHALL enter WAIT, latch req_pc = fetch_pc, and set fetch_pc = fetch_pc + 4, wrapping modulo 2^PC_WIDTH.
REQ-022 In WAIT, imem_resp_valid SHALL push {req_pc, imem_resp_data} into the 2-entry buffer and return the FSM to REQ.
REQ-023 Request-to-id_valid latency SHALL be one cycle after the response cycle; no combinational path from imem_resp_* to id_*.
REQ-024 id_valid SHALL be (buffer not empty) && !redirect_valid; id_pc/id_instr SHALL be the buffer head.
REQ-025 A push and a pop in the same cycle SHALL leave occupancy unchanged; a push into a full buffer SHALL be impossible by REQ-019.
REQ-026 redirect_valid SHALL take priority over the pc+4 update: fetch_pc = {redirect_pc[PC_WIDTH-1:2], 2'b00}, and the buffer SHALL be emptied that cycle.
REQ-027 A redirect in WAIT, or in REQ coincident with request acceptance, SHALL move the FSM to DROP.
REQ-028 In DROP, the response SHALL be discarded without a push and the FSM SHALL return to REQ; a redirect in DROP SHALL update fetch_pc and remain in DROP.
REQ-029 A redirect coincident with a response in WAIT SHALL discard that response.

Reset
REQ-030 Asserting rst_n low SHALL immediately set fetch_pc = RESET_PC, the FSM to REQ, occupancy to 0, and drive imem_req_valid = 0, id_valid = 0, id_pc = 0 and id_instr = 0.
REQ-031 The first request SHALL be presented in the first cycle after rst_n deasserts.
REQ-032 Reset mid-request SHALL abandon the outstanding request; the environment SHALL not deliver its response after reset.

Structure
REQ-033 PC_WIDTH, INSTR_WIDTH, RESET_PC defaults and the FSM state enum SHALL live in the shared pipeline package.
REQ-034 The 2-entry buffer SHALL be a sub-module fetch_fifo (push/pop/flush, full/empty, head outputs).

Verification
REQ-035 Reset release with imem_req_ready = 1 and a 1-cycle response latency: the bench SHALL observe addresses 0x0, 0x4, 0x8 and id_pc 0x0, 0x4, 0x8 in order.
REQ-036 id_ready held at 0: exactly 2 instructions SHALL buffer, after which imem_req_valid = 0; raising id_ready SHALL resume fetch at 0x8.
REQ-037 Redirect to 0x100 while in WAIT for 0x4: the 0x4 response SHALL be dropped, and the next request and id_pc SHALL be 0x100.
REQ-038 Redirect to 0x203 with 2 entries buffered: id_valid SHALL be 0 that cycle, the buffer SHALL be empty next cycle, and the next address SHALL be 0x200.
REQ-039 fetch_pc = 2^64-4 accepted: the next address SHALL be 0x0.
REQ-040 rst_n asserted while in WAIT: outputs SHALL clear immediately, and the first request after release SHALL be RESET_PC.
